// File: rtl/gray_conv_arbiter_pkg.sv
// Shared definitions for the round-robin Gray-converter arbiter: FSM encoding,
// operand width and default requester configuration.
package gray_conv_arbiter_pkg;

    localparam int GC_DW    = 8;
    localparam int DEF_NREQ = 4;
    localparam int DEF_IDW  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/gray_conv_arbiter_bin2gray.sv
// Existing 8-bit gate-level binary-to-Gray converter. Each nibble is converted
// independently, so bit 3 passes straight through like bit 7.
module bin2gray
    import gray_conv_arbiter_pkg::*;
(
    input  logic [GC_DW-1:0] bin,
    output logic [GC_DW-1:0] gray
);

    assign gray[7]   = bin[7];
    assign gray[6:4] = bin[7:5] ^ bin[6:4];
    assign gray[3]   = bin[3];
    assign gray[2:0] = bin[3:1] ^ bin[2:0];

endmodule

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter sharing one bin2gray converter between NREQ requesters.
// Optional macro GRAY_PARITY_EN adds out_par, the XOR of the registered out_gray.
module gray_conv_arbiter
    import gray_conv_arbiter_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IDW  = DEF_IDW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [GC_DW*NREQ-1:0] bin_in,
    output logic [NREQ-1:0]       ack,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [GC_DW-1:0]      out_gray,
    output logic [IDW-1:0]        out_id,
`ifdef GRAY_PARITY_EN
    output logic                  out_par,
`endif
    output logic                  busy
);

    state_t           state, state_nxt;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   id_reg;
    logic [IDW-1:0]   winner;
    logic [GC_DW-1:0] op_reg;
    logic [GC_DW-1:0] gray_res;
    logic [GC_DW-1:0] ops [NREQ];

    // First requester strictly after ptr, wrapping modulo NREQ; ptr itself is searched last.
    function automatic logic [IDW-1:0] rr_next(input logic [NREQ-1:0] r,
                                               input logic [IDW-1:0]  ptr);
        logic [IDW:0]   cand;
        logic [IDW-1:0] win;
        logic           found;
        win   = ptr;
        found = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = {1'b0, ptr} + (IDW+1)'(i);
            if (cand >= (IDW+1)'(NREQ)) begin
                cand = cand - (IDW+1)'(NREQ);
            end
            if (!found && r[cand[IDW-1:0]]) begin
                found = 1'b1;
                win   = cand[IDW-1:0];
            end
        end
        return win;
    endfunction

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            ops[i] = bin_in[i*GC_DW +: GC_DW];
        end
    end

    assign winner = rr_next(req, rr_ptr);

    bin2gray u_bin2gray (
        .bin  (op_reg),
        .gray (gray_res)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block is given a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|req) state_nxt = CONV;
            CONV:    state_nxt = HOLD;
            HOLD:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ack is decoded from the state so an asynchronous reset clears it at once.
    always_comb begin
        ack = '0;
        if (state == CONV) begin
            ack[id_reg] = 1'b1;
        end
    end

    assign busy = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= IDW'(NREQ - 1);
            id_reg    <= '0;
            op_reg    <= '0;
            out_valid <= 1'b0;
            out_gray  <= '0;
            out_id    <= '0;
`ifdef GRAY_PARITY_EN
            out_par   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        op_reg <= ops[winner];
                        id_reg <= winner;
                        rr_ptr <= winner;
                    end
                end
                CONV: begin
                    out_gray  <= gray_res;
                    out_id    <= id_reg;
                    out_valid <= 1'b1;
`ifdef GRAY_PARITY_EN
                    out_par   <= ^gray_res;
`endif
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Directed bench for gray_conv_arbiter: reset, single request, round-robin order,
// backpressure, withdrawal, fairness, mid-operation reset and boundary operands.
module tb_gray_conv_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] bin_in = '0;
    logic [3:0]  ack;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_gray;
    logic [1:0]  out_id;
    logic        busy;
`ifdef GRAY_PARITY_EN
    logic        out_par;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    gray_conv_arbiter #(.NREQ(4), .IDW(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .bin_in    (bin_in),
        .ack       (ack),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_gray  (out_gray),
        .out_id    (out_id),
`ifdef GRAY_PARITY_EN
        .out_par   (out_par),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Steps negedges until some ack is seen or the budget expires; no checking here.
    task automatic wait_ack(output bit timeout, output int at_cyc);
        int n;
        n = 0;
        while (ack == '0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        timeout = (ack == '0);
        at_cyc  = cyc;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        checks++;
        if (ack !== 4'b0000 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: ack=%b out_valid=%b busy=%b, want 0000 0 0", ack, out_valid, busy);
        end
        checks++;
        if (out_gray !== 8'h00 || out_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_data: out_gray=%h out_id=%0d, want 00 0", out_gray, out_id);
        end
`ifdef GRAY_PARITY_EN
        checks++;
        if (out_par !== 1'b0) begin
            errors++;
            $display("FAIL reset_par: out_par=%b, want 0", out_par);
        end
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single();
        @(negedge clk);
        req = 4'b0001;
        bin_in[7:0] = 8'h5A;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (ack !== 4'b0001 || busy !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_ack: ack=%b busy=%b out_valid=%b, want 0001 1 0", ack, busy, out_valid);
        end
        req = 4'b0000;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_gray !== 8'h7F || out_id !== 2'd0 || ack !== 4'b0000) begin
            errors++;
            $display("FAIL single_result: valid=%b gray=%h id=%0d ack=%b, want 1 7f 0 0000",
                     out_valid, out_gray, out_id, ack);
        end
`ifdef GRAY_PARITY_EN
        checks++;
        if (out_par !== 1'b1) begin
            errors++;
            $display("FAIL single_par: out_par=%b, want 1", out_par);
        end
`endif
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: out_valid=%b busy=%b, want 0 0", out_valid, busy);
        end
    endtask

    task automatic test_all_four();
        logic [7:0] exp_gray [4];
        bit         to;
        int         at;
        int         prev;
        exp_gray[0] = 8'h13;
        exp_gray[1] = 8'hC0;
        exp_gray[2] = 8'h88;
        exp_gray[3] = 8'h24;
        prev = -1;
        apply_reset();
        bin_in    = {8'h37, 8'hFF, 8'h80, 8'h12};
        out_ready = 1'b1;
        req       = 4'b1111;
        for (int j = 0; j < 4; j++) begin
            wait_ack(to, at);
            checks++;
            if (to || ack !== (4'b0001 << j)) begin
                errors++;
                $display("FAIL all4_grant%0d: ack=%b timeout=%0d, want %b", j, ack, to, 4'b0001 << j);
            end
            if (j > 0) begin
                checks++;
                if (at - prev != 3) begin
                    errors++;
                    $display("FAIL all4_spacing%0d: %0d cycles, want 3", j, at - prev);
                end
            end
            prev = at;
            req[j] = 1'b0;
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_gray !== exp_gray[j] || out_id !== 2'(j)) begin
                errors++;
                $display("FAIL all4_result%0d: valid=%b gray=%h id=%0d, want 1 %h %0d",
                         j, out_valid, out_gray, out_id, exp_gray[j], j);
            end
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL all4_idle: busy=%b, want 0", busy);
        end
    endtask

    task automatic test_backpressure();
        bit to;
        int at;
        out_ready    = 1'b0;
        bin_in[15:8] = 8'hA5;
        req          = 4'b0010;
        wait_ack(to, at);
        checks++;
        if (to || ack !== 4'b0010) begin
            errors++;
            $display("FAIL bp_ack: ack=%b timeout=%0d, want 0010", ack, to);
        end
        req = 4'b0000;
        @(negedge clk);
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (out_valid !== 1'b1 || out_gray !== 8'hF7 || out_id !== 2'd1 ||
                busy !== 1'b1 || ack !== 4'b0000) begin
                errors++;
                $display("FAIL bp_hold%0d: valid=%b gray=%h id=%0d busy=%b ack=%b, want 1 f7 1 1 0000",
                         c, out_valid, out_gray, out_id, busy, ack);
            end
            if (c == 3) req[2] = 1'b1;
            if (c == 4) req[2] = 1'b0;
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: out_valid=%b busy=%b, want 0 0", out_valid, busy);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (ack !== 4'b0000 || busy !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL withdraw%0d: ack=%b busy=%b valid=%b, want 0000 0 0", c, ack, busy, out_valid);
            end
        end
    endtask

    task automatic test_fairness();
        int exp_id [4];
        bit to;
        int at;
        exp_id[0] = 1;
        exp_id[1] = 3;
        exp_id[2] = 1;
        exp_id[3] = 3;
        bin_in[31:24] = 8'h37;
        req = 4'b0010;
        for (int j = 0; j < 4; j++) begin
            wait_ack(to, at);
            checks++;
            if (to || ack !== (4'b0001 << exp_id[j])) begin
                errors++;
                $display("FAIL fair_grant%0d: ack=%b timeout=%0d, want %b", j, ack, to, 4'b0001 << exp_id[j]);
            end
            if (j == 0) req[3] = 1'b1;
            if (j == 3) req = 4'b0000;
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_id !== 2'(exp_id[j])) begin
                errors++;
                $display("FAIL fair_id%0d: valid=%b id=%0d, want 1 %0d", j, out_valid, out_id, exp_id[j]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit to;
        int at;
        bin_in = {8'h37, 8'hFF, 8'h80, 8'h12};
        req    = 4'b0100;
        wait_ack(to, at);
        checks++;
        if (to || ack !== 4'b0100) begin
            errors++;
            $display("FAIL rmid_pre: ack=%b timeout=%0d, want 0100", ack, to);
        end
        req = 4'b1111;
        rst = 1'b1;
        #1;
        checks++;
        if (ack !== 4'b0000 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rmid_async: ack=%b valid=%b busy=%b, want 0000 0 0", ack, out_valid, busy);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || ack !== 4'b0000) begin
            errors++;
            $display("FAIL rmid_discard: valid=%b ack=%b, want 0 0000", out_valid, ack);
        end
        rst = 1'b0;
        wait_ack(to, at);
        checks++;
        if (to || ack !== 4'b0001) begin
            errors++;
            $display("FAIL rmid_grant: ack=%b timeout=%0d, want 0001", ack, to);
        end
        req = 4'b0000;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_gray !== 8'h13 || out_id !== 2'd0) begin
            errors++;
            $display("FAIL rmid_result: valid=%b gray=%h id=%0d, want 1 13 0", out_valid, out_gray, out_id);
        end
        @(negedge clk);
    endtask

    task automatic test_boundary();
        logic [7:0] ops [2];
        logic [7:0] exp [2];
        bit to;
        int at;
        ops[0] = 8'h00;
        ops[1] = 8'hFF;
        exp[0] = 8'h00;
        exp[1] = 8'h88;
        out_ready = 1'b1;
        for (int j = 0; j < 2; j++) begin
            bin_in[7:0] = ops[j];
            req = 4'b0001;
            wait_ack(to, at);
            checks++;
            if (to || ack !== 4'b0001) begin
                errors++;
                $display("FAIL bound_ack%0d: ack=%b timeout=%0d, want 0001", j, ack, to);
            end
            req = 4'b0000;
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_gray !== exp[j]) begin
                errors++;
                $display("FAIL bound_gray%0d: valid=%b gray=%h, want 1 %h", j, out_valid, out_gray, exp[j]);
            end
`ifdef GRAY_PARITY_EN
            checks++;
            if (out_par !== 1'b0) begin
                errors++;
                $display("FAIL bound_par%0d: out_par=%b, want 0", j, out_par);
            end
`endif
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_backpressure();
        test_fairness();
        test_reset_mid();
        test_boundary();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gray_conv_arbiter.md
Name: gray_conv_arbiter

Overview:
- Shares one 8-bit binary-to-Gray converter (existing module bin2gray) between NREQ requesters.
- Round-robin arbitration; captures the winner's operand and returns the registered result with the requester ID over a valid/ready interface.
- Sits between the requesting blocks and the single shared converter instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester ID width; must equal ceil(log2(NREQ)).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- req  input  NREQ  per-requester request level.
- bin_in  input  8*NREQ  operands; requester i occupies bits [8i+7:8i].
- ack  output  NREQ  one-cycle pulse: operand of requester i captured.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts the result.
- out_gray  output  8  converted result.
- out_id  output  IDW  ID of the requester that owns out_gray.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Conversion is per-nibble Gray, exactly as bin2gray produces it: gray[7]=b[7], gray[6:4]=b[7:5]^b[6:4], gray[3]=b[3], gray[2:0]=b[3:1]^b[2:0].
- Reset values (async, immediate): ack=0, out_valid=0, out_gray=0, out_id=0, busy=0, state=IDLE, rr_ptr=NREQ-1.
- FSM states: IDLE, CONV, HOLD.
- IDLE, no req bit set: stay in IDLE.
- IDLE, any req bit set at edge k:
  - Winner is the first set bit searching rr_ptr+1, rr_ptr+2, ... modulo NREQ.
  - Latch bin_in[winner] into op_reg and winner into id_reg; set rr_ptr=winner; go to CONV.
- CONV: ack[id_reg]=1 for this cycle only (cycle k+1).
  - At edge k+1: out_gray <= bin2gray(op_reg), out_id <= id_reg, out_valid <= 1; go to HOLD.
- HOLD: out_valid, out_gray and out_id stay stable until out_valid && out_ready.
  - At that edge: out_valid <= 0; go to IDLE.
- Latency: first out_valid at cycle k+2.
  - out_ready held high gives one result per 3 cycles.
  - The next arbitration samples req in the cycle after the handshake.
- Requester rules:
  - Hold req and bin_in stable until ack.
  - Drop req in the ack cycle unless requesting again.
  - req still high after ack counts as a new transaction.
  - req withdrawn before capture is never served and never acked.
- Fairness: a continuously requesting requester waits at most NREQ-1 transactions.
- Simultaneous requests are resolved only by rr_ptr; there is no fixed priority after reset.
- out_ready while out_valid=0 is ignored.
- rst mid-operation: any pending result is discarded and no ack is issued; after reset, requester 0 has highest priority.
- ack is at most one-hot.

Optional Feature:
- Macro GRAY_PARITY_EN.
- Defined:
  - Adds output port out_par (1 bit), the even parity of out_gray (XOR of its 8 bits).
  - Registered in the same edge as out_gray; reset 0; stable in HOLD.
- Undefined: the port does not exist and there is no parity logic; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - State encodings: IDLE=2'd0, CONV=2'd1, HOLD=2'd2.
  - Operand width constant GC_DW=8.
  - Default NREQ/IDW.
- Sub-module: bin2gray, the existing 8-bit gate-level converter, instantiated once on op_reg.
- Round-robin next-winner search is a function inside gray_conv_arbiter; no separate module.

Test Plan:
- Single requester: req[0]=1, bin_in[0]=8'h5A → ack[0] pulse in cycle k+1; out_valid in k+2 with out_gray=8'h7F, out_id=0; out_par=1 if GRAY_PARITY_EN.
- All four requesting with operands 8'h12, 8'h80, 8'hFF, 8'h37, out_ready=1:
  - Grant order 0,1,2,3.
  - Results 8'h13, 8'hC0, 8'h88, 8'h24.
  - ack pulses spaced 3 cycles apart.
- Backpressure: out_ready=0 for 10 cycles after out_valid → out_gray/out_id constant, busy=1, no ack issued; out_ready=1 → exactly one handshake, then IDLE.
- Fairness: req[1] held continuously, req[3] asserted later → grants alternate 1,3,1,3; no requester is skipped.
- Withdrawal and reset:
  - req[2] pulsed one cycle while in HOLD → never acked.
  - rst asserted in CONV → out_valid and ack immediately 0; the next grant after release goes to requester 0 when req=4'b1111.
- Boundary operands: 8'h00 → 8'h00 and 8'hFF → 8'h88, with out_par 0 and 0 respectively.
